// File: rtl/sigma_irq_pkg.sv
// Shared types and constants for the sigma interrupt controller.
package sigma_irq_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;

endpackage

// File: rtl/sigma_irq_debounce.sv
// Per-source 2-flop synchronizer followed by an optional stability filter.
module sigma_irq_debounce
  import sigma_irq_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic        BYPASS          = 1'b0
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic src_i,
  output logic level_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter holds the number of consecutive differing samples already seen;
  // the level flips on the next differing sample, i.e. DEBOUNCE_CYCLES cycles
  // later than the bypass path.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (BYPASS) begin
      level_d = sync2_q;
    end else if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_comb level_o = level_q;

endmodule

// File: rtl/sigma_irq_ctrl.sv
// Interrupt controller: filtered edge capture, fixed-priority arbitration and a
// req/ack/eoi handshake towards the sigma CPU, with a small config register port.
module sigma_irq_ctrl
  import sigma_irq_pkg::*;
#(
  parameter int unsigned           NUM_SRC         = 4,
  parameter logic [15:0]           DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [NUM_SRC-1:0]    DEBOUNCE_MASK   = 4'b0001
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic [NUM_SRC-1:0]  src_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [31:0]         cfg_wdata_i,
  output logic [31:0]         cfg_rdata_o,
  output logic                irq_req_o,
  output logic [CODE_W-1:0]   irq_code_o,
  input  logic                irq_ack_i,
  input  logic                irq_eoi_i
);

  logic [NUM_SRC-1:0] level, rise, cand;
  logic [NUM_SRC-1:0] level_prev_q;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  code_q, code_d, win;
  irq_state_e         state_q, state_d;
  logic               unused_wdata;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    sigma_irq_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BYPASS          (~DEBOUNCE_MASK[gi])
    ) u_db (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .src_i   (src_i[gi]),
      .level_o (level[gi])
    );
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      level_prev_q <= '0;
      enable_q     <= '0;
      pending_q    <= '0;
      code_q       <= '0;
      state_q      <= IDLE;
    end else begin
      level_prev_q <= level;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      code_q       <= code_d;
      state_q      <= state_d;
    end
  end

  always_comb begin
    rise = level & ~level_prev_q;
    cand = pending_q & enable_q;
    win  = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (cand[i-1]) win = CODE_W'(i - 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    if (cfg_we_i && cfg_addr_i == REG_ENABLE) enable_d = cfg_wdata_i[NUM_SRC-1:0];
    if (cfg_we_i && cfg_addr_i == REG_PENDING) pending_d = pending_d & ~cfg_wdata_i[NUM_SRC-1:0];
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          code_d  = win;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = SVC;
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (code_q == CODE_W'(i)) pending_d[i] = 1'b0;
          end
        end
      end
      SVC: begin
        if (irq_eoi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // New edges are merged last so they win over any clear in the same cycle.
    pending_d = pending_d | rise;
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      REG_ENABLE:  cfg_rdata_o[NUM_SRC-1:0] = enable_q;
      REG_PENDING: cfg_rdata_o[NUM_SRC-1:0] = pending_q;
      REG_STATUS: begin
        cfg_rdata_o[CODE_W-1:0] = code_q;
        cfg_rdata_o[5:4]        = state_q;
      end
      default: cfg_rdata_o = '0;
    endcase
  end

  always_comb begin
    irq_req_o    = (state_q == REQ);
    irq_code_o   = code_q;
    unused_wdata = ^cfg_wdata_i[31:NUM_SRC];
  end

endmodule

// File: tb/tb_sigma_irq_ctrl.sv
// Directed bench for sigma_irq_ctrl with a sample-history reference model.
module tb_sigma_irq_ctrl;
  import sigma_irq_pkg::*;

  localparam int D = 8;
  localparam logic [3:0] MASK = 4'b0001;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [3:0]  src = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        irq_req;
  logic [2:0]  irq_code;
  logic        ack = 1'b0;
  logic        eoi = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sigma_irq_ctrl #(
    .NUM_SRC         (4),
    .DEBOUNCE_CYCLES (16'd8),
    .DEBOUNCE_MASK   (4'b0001)
  ) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .src_i       (src),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .irq_req_o   (irq_req),
    .irq_code_o  (irq_code),
    .irq_ack_i   (ack),
    .irq_eoi_i   (eoi)
  );

  // Reference model: sample history per edge; state 0=idle 1=req 2=svc.
  bit [3:0] m_samp [0:15];
  bit [3:0] m_filt, m_filt_prev, m_pend, m_en;
  bit [1:0] m_state;
  bit [2:0] m_code;

  always @(posedge clk or negedge arstn) begin : model
    bit [3:0] rise, nf, clr, c, old_pend, old_en;
    bit       all_diff;
    int       k;
    if (!arstn) begin
      for (int j = 0; j < 16; j++) m_samp[j] = '0;
      m_filt = '0; m_filt_prev = '0; m_pend = '0; m_en = '0;
      m_state = 2'd0; m_code = '0;
    end else begin
      for (int j = 15; j > 0; j--) m_samp[j] = m_samp[j-1];
      m_samp[0] = src;
      rise = m_filt & ~m_filt_prev;
      for (int i = 0; i < 4; i++) begin
        if (MASK[i]) begin
          all_diff = 1'b1;
          for (int j = 2; j <= 2 + D; j++) if (m_samp[j][i] == m_filt[i]) all_diff = 1'b0;
          nf[i] = all_diff ? ~m_filt[i] : m_filt[i];
        end else begin
          nf[i] = m_samp[2][i];
        end
      end
      m_filt_prev = m_filt;
      m_filt      = nf;
      old_pend = m_pend;
      old_en   = m_en;
      clr = '0;
      if (cfg_we && cfg_addr == 2'd1) clr = cfg_wdata[3:0];
      if (cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata[3:0];
      case (m_state)
        2'd0: begin
          c = old_pend & old_en;
          if (c != 0) begin
            k = 0;
            while (!c[k]) k++;
            m_code  = 3'(k);
            m_state = 2'd1;
          end
        end
        2'd1: if (ack) begin clr[m_code] = 1'b1; m_state = 2'd2; end
        default: if (eoi) m_state = 2'd0;
      endcase
      m_pend = (old_pend & ~clr) | rise;
    end
  end

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_en};
      2'd1:    return {28'd0, m_pend};
      2'd2:    return {26'd0, m_state, 1'b0, m_code};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("cyc_req", {31'd0, irq_req}, {31'd0, m_state == 2'd1});
    chk("cyc_code", {29'd0, irq_code}, {29'd0, m_code});
    chk("cyc_rdata", cfg_rdata, m_rdata(cfg_addr));
  end

  task automatic wait_pos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk); cfg_we = 1'b0; cfg_addr = REG_PENDING; cfg_wdata = '0;
  endtask

  task automatic pulse_ack;
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic pulse_eoi;
    @(negedge clk); eoi = 1'b1;
    @(negedge clk); eoi = 1'b0;
  endtask

  initial begin
    int k;
    // Reset values
    wait_pos(2);
    chk("rst_req", {31'd0, irq_req}, 32'd0);
    chk("rst_code", {29'd0, irq_code}, 32'd0);
    chk("rst_rdata0", cfg_rdata, 32'd0);
    @(negedge clk); arstn = 1'b1; cfg_addr = REG_PENDING;

    // Enable gating with undebounced source 1
    @(negedge clk); src = 4'b0010;
    wait_pos(3);
    chk("gate_pend_n2", cfg_rdata, 32'h0);
    wait_pos(1);
    chk("gate_pend_n3", cfg_rdata, 32'h2);
    wait_pos(3);
    chk("gate_noreq", {31'd0, irq_req}, 32'd0);
    wr(REG_ENABLE, 32'h2);
    wait_pos(1);
    chk("gate_req", {31'd0, irq_req}, 32'd1);
    chk("gate_code", {29'd0, irq_code}, 32'd1);

    // Handshake robustness: eoi in REQ, ack in SVC and in IDLE
    pulse_eoi;
    wait_pos(1);
    chk("eoi_in_req", {31'd0, irq_req}, 32'd1);
    chk("eoi_in_req_pend", cfg_rdata, 32'h2);
    pulse_ack;
    #1;
    chk("ack_drop", {31'd0, irq_req}, 32'd0);
    chk("ack_clear", cfg_rdata, 32'h0);
    pulse_ack;
    cfg_addr = REG_STATUS; #1;
    chk("ack_in_svc", cfg_rdata, 32'h21);
    src = 4'b0000;
    pulse_eoi;
    cfg_addr = REG_STATUS; #1;
    chk("eoi_idle", cfg_rdata, 32'h01);
    pulse_ack;
    #1;
    chk("ack_in_idle", cfg_rdata, 32'h01);
    cfg_addr = REG_PENDING;

    // Priority between sources 3 and 1
    wr(REG_ENABLE, 32'hF);
    repeat (3) @(negedge clk);
    @(negedge clk); src = 4'b1010;
    wait_pos(4);
    chk("prio_pend", cfg_rdata, 32'ha);
    chk("prio_idle", {31'd0, irq_req}, 32'd0);
    wait_pos(1);
    chk("prio_req1", {31'd0, irq_req}, 32'd1);
    chk("prio_code1", {29'd0, irq_code}, 32'd1);
    pulse_ack;
    #1;
    chk("prio_pend_after_ack", cfg_rdata, 32'h8);
    pulse_eoi;
    wait_pos(1);
    chk("prio_req2", {31'd0, irq_req}, 32'd1);
    chk("prio_code2", {29'd0, irq_code}, 32'd3);
    pulse_ack;
    src = 4'b0000;
    pulse_eoi;
    #1;
    chk("prio_pend_end", cfg_rdata, 32'h0);

    // Set wins over W1C in the same cycle
    wr(REG_ENABLE, 32'h0);
    repeat (4) @(negedge clk);
    @(negedge clk); src = 4'b0010;
    repeat (3) @(posedge clk);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = REG_PENDING; cfg_wdata = 32'h2;
    wait_pos(1);
    chk("set_wins", cfg_rdata, 32'h2);
    @(negedge clk); cfg_we = 1'b0; cfg_wdata = '0; src = 4'b0000;
    wr(REG_PENDING, 32'h2);
    #1;
    chk("w1c_alone", cfg_rdata, 32'h0);

    // Debounce on source 0: glitches rejected, stable level accepted
    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); src[0] = 1'b1;
      repeat (5) @(negedge clk);
      src[0] = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("glitch_none", cfg_rdata, 32'h0);
    @(negedge clk); src[0] = 1'b1;
    wait_pos(11);
    chk("db_pend_n10", cfg_rdata, 32'h0);
    wait_pos(1);
    chk("db_pend_n11", cfg_rdata, 32'h1);
    @(negedge clk); src[0] = 1'b0;
    repeat (14) @(negedge clk);
    wr(REG_PENDING, 32'h1);
    #1;
    chk("db_cleared", cfg_rdata, 32'h0);

    // Reset while a request is outstanding
    wr(REG_ENABLE, 32'hF);
    @(negedge clk); src = 4'b0100;
    repeat (2) @(negedge clk);
    src = 4'b0000;
    k = 0;
    while (!irq_req && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rstreq_seen", {31'd0, irq_req}, 32'd1);
    @(negedge clk); arstn = 1'b0;
    #1;
    chk("rstreq_req", {31'd0, irq_req}, 32'd0);
    chk("rstreq_code", {29'd0, irq_code}, 32'd0);
    chk("rstreq_pend", cfg_rdata, 32'h0);
    cfg_addr = REG_STATUS; #1;
    chk("rstreq_status", cfg_rdata, 32'h0);
    cfg_addr = REG_ENABLE; #1;
    chk("rstreq_enable", cfg_rdata, 32'h0);
    cfg_addr = REG_PENDING;
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    wait_pos(10);
    chk("rstreq_after_req", {31'd0, irq_req}, 32'd0);
    chk("rstreq_after_pend", cfg_rdata, 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
